// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache fill controller: state encoding and default line size.
package cache_ctrl_pkg;

  localparam int CNT_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    TAG    = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/fill_counter.sv
// Refill word counter: advances one word per enabled cycle and wraps modulo the line length.
module fill_counter
  import cache_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt,
  output logic [CNT_W-1:0] dout,
  output logic             end_o
);

  logic [CNT_W-1:0] dout_q;
  logic [CNT_W-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (cnt) begin
      dout_d = dout_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign end_o = (dout_q == {CNT_W{1'b1}});

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache access controller: Moore FSM for lookup / line refill / tag write / response.
// Build option RETRY_LOOKUP_EN: after the tag write the line is looked up again instead of responding.
module cache_fill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c,
  input  logic             v,
  output logic             twr,
  output logic             dwr,
  output logic             rwr,
  output logic             cnt,
  output logic             mux,
  output logic [CNT_W-1:0] dout,
  output logic             end_o
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend on the state only; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    twr     = 1'b0;
    dwr     = 1'b0;
    rwr     = 1'b0;
    cnt     = 1'b0;
    mux     = 1'b0;
    case (state_q)
      IDLE: begin
        if (v) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = c ? RESP : FILL;
      end
      FILL: begin
        cnt = 1'b1;
        dwr = 1'b1;
        mux = 1'b1;
        if (end_o) begin
          state_d = TAG;
        end
      end
      TAG: begin
        twr = 1'b1;
        mux = 1'b1;
`ifdef RETRY_LOOKUP_EN
        state_d = LOOKUP;
`else
        state_d = RESP;
`endif
      end
      RESP: begin
        rwr     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  fill_counter #(
    .CNT_W(CNT_W)
  ) u_fill_counter (
    .clk  (clk),
    .reset(reset),
    .cnt  (cnt),
    .dout (dout),
    .end_o(end_o)
  );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: randomized hit/miss traffic against a transaction-level model.
module tb_cache_fill_ctrl;

  localparam int CNT_W = 3;
  localparam int LINE  = 1 << CNT_W;
  localparam int OW    = 6 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             c = 1'b0;
  logic             v = 1'b0;
  logic             twr, dwr, rwr, cnt, mux, end_o;
  logic [CNT_W-1:0] dout;

  cache_fill_ctrl #(
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .c    (c),
    .v    (v),
    .twr  (twr),
    .dwr  (dwr),
    .rwr  (rwr),
    .cnt  (cnt),
    .mux  (mux),
    .dout (dout),
    .end_o(end_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [OW-1:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [OW-1:0] pack(input bit p_twr, input bit p_dwr, input bit p_rwr,
                                         input bit p_cnt, input bit p_mux, input bit p_end,
                                         input int p_dout);
    logic [CNT_W-1:0] d;
    d = p_dout[CNT_W-1:0];
    return {p_twr, p_dwr, p_rwr, p_cnt, p_mux, p_end, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any cycle with an asserted strobe must match the head of the scoreboard.
  logic [OW-1:0] mon_outs;
  exp_t          mon_e;
  always @(negedge clk) begin
    if (reset) begin
      mon_outs = {twr, dwr, rwr, cnt, mux, end_o, dout};
      if (twr | dwr | rwr | cnt | mux | end_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 32'(mon_outs), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("output_cycle", cyc, mon_e.at);
          checkOutput("output_value", 32'(mon_outs), 32'(mon_e.outs));
        end
      end else begin
        checkOutput("quiet_dout", 32'(dout), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
          mon_e = exp_q.pop_front();
          checkOutput("missed_output", 32'(mon_outs), 32'(mon_e.outs));
        end
      end
    end
  end

  // One request issued from IDLE; the model lists every strobe cycle the spec implies.
  task automatic applyStimulus(input bit hit, input bit hold);
    int n;
    int resp;
    exp_t e;
    n = cyc;
    v = 1'b1;
    if (hit) begin
      resp = n + 2;
    end else begin
      for (int i = 0; i < LINE; i++) begin
        e.at   = n + 2 + i;
        e.outs = pack(0, 1, 0, 1, 1, (i == LINE - 1), i);
        exp_q.push_back(e);
      end
      e.at   = n + 2 + LINE;
      e.outs = pack(1, 0, 0, 0, 1, 0, 0);
      exp_q.push_back(e);
`ifdef RETRY_LOOKUP_EN
      resp = n + 4 + LINE;
`else
      resp = n + 3 + LINE;
`endif
    end
    e.at   = resp;
    e.outs = pack(0, 0, 1, 0, 0, 0, 0);
    exp_q.push_back(e);
    step();
    for (int k = n + 1; k <= resp; k++) begin
      if (k == n + 1) c = hit;
`ifdef RETRY_LOOKUP_EN
      else if (!hit && k == resp - 1) c = 1'b1;
`endif
      else c = 1'($urandom_range(0, 1));
      v = hold ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic idleCycles(input int k);
    v = 1'b0;
    repeat (k) step();
  endtask

  task automatic checkQuiet(input string name);
    checkOutput(name, 32'({twr, dwr, rwr, cnt, mux, end_o, dout}), 32'd0);
  endtask

  // Miss interrupted by an asynchronous reset while word 5 is being written.
  task automatic resetMidFill();
    int n;
    exp_t e;
    n = cyc;
    v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.at   = n + 2 + i;
      e.outs = pack(0, 1, 0, 1, 1, 0, i);
      exp_q.push_back(e);
    end
    step();
    for (int k = n + 1; k <= n + 6; k++) begin
      c = (k == n + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      step();
    end
    checkOutput("pre_reset_dout", 32'(dout), 32'd5);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_dout", 32'(dout), 32'd0);
    checkOutput("async_reset_dwr", 32'(dwr), 32'd0);
    checkOutput("async_reset_cnt", 32'(cnt), 32'd0);
    checkQuiet("async_reset_all");
    v = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting cache_fill_ctrl bench");
    reset = 1'b0;
    v     = 1'b1;
    c     = 1'b0;
    #1;
    checkQuiet("reset_initial");
    repeat (3) begin
      step();
      checkQuiet("reset_held");
    end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    idleCycles(2);

    applyStimulus(1'b0, 1'b0);
    idleCycles(1);

    for (int t = 0; t < 3; t++) applyStimulus(1'b1, 1'b1);
    idleCycles(1);

    resetMidFill();
    applyStimulus(1'b1, 1'b0);
    idleCycles(1);

    for (int t = 0; t < 30; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      idleCycles($urandom_range(0, 2));
    end

    idleCycles(4);
    checkOutput("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
